// File: rtl/pdm_cic_interpolator_if.sv
// ----------------------------------------------------------------------------
// pdm_cic_interpolator_if
//
// Sample request/handshake bundle for the PDM CIC interpolator.
//   sample_in     unsigned input sample, IN_WIDTH bits (source -> interpolator)
//   sample_valid  sample_in holds a valid sample    (source -> interpolator)
//   sample_ready  one-cycle request strobe           (interpolator -> source)
//   underrun      one-cycle pulse: request not met   (interpolator -> source)
//   pdm_out       1-bit PDM bitstream, one per clk   (interpolator -> DAC)
//
// master: the sample source side.  slave: the interpolator.
// ----------------------------------------------------------------------------
interface pdm_cic_interpolator_if #(
    parameter int IN_WIDTH = 4
);
    logic [IN_WIDTH-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;
    logic                underrun;
    logic                pdm_out;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready,
        input  underrun,
        input  pdm_out
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready,
        output underrun,
        output pdm_out
    );
endinterface

// File: rtl/pdm_cic_interpolator.sv
// ----------------------------------------------------------------------------
// pdm_cic_interpolator
//
// Transmit-side partner of the PDM CIC decimator. Requests one unsigned sample
// every INTERP clocks, upsamples it with a STAGES-order CIC interpolator
// (comb at the low rate, zero-stuff, integrators at clk rate), removes the CIC
// DC gain exactly and turns the result into a 1-bit PDM stream with a
// first-order sigma-delta modulator.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   bus    slave side of pdm_cic_interpolator_if (sample_in, sample_valid,
//          sample_ready, underrun, pdm_out); its IN_WIDTH must match ours
// ----------------------------------------------------------------------------
module pdm_cic_interpolator #(
    parameter int  STAGES      = 2,
    parameter int  INTERP      = 4,
    parameter int  LOG2_INTERP = 2,
    parameter int  IN_WIDTH    = 4,
    localparam int ACC_WIDTH   = IN_WIDTH + (STAGES - 1) * LOG2_INTERP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pdm_cic_interpolator_if.slave    bus
);

    // Ready is registered, so it is computed one phase early: it is high
    // exactly while phase == INTERP-1.
    localparam logic [LOG2_INTERP-1:0] PRE_LAST_PHASE = LOG2_INTERP'(INTERP - 2);

    logic [LOG2_INTERP-1:0] phase;
    logic                   ready_q;
    logic                   underrun_q;
    logic                   pdm_q;
    logic [IN_WIDTH-1:0]    held;

    logic [ACC_WIDTH-1:0]   d  [STAGES];   // comb delays, low rate
    logic [ACC_WIDTH-1:0]   c  [STAGES];   // comb outputs, combinational
    logic [ACC_WIDTH-1:0]   g  [STAGES];   // integrators, clk rate
    logic [ACC_WIDTH-1:0]   zs;            // zero-stuffed comb output

    logic [IN_WIDTH-1:0]    x_sel;
    logic [ACC_WIDTH-1:0]   x_ext;
    logic [IN_WIDTH-1:0]    y;

    // Only the low IN_WIDTH bits of the modulator accumulator carry state; the
    // carry out of each sum is exactly the PDM bit and lives in pdm_q.
    logic [IN_WIDTH-1:0]    acc;
    logic [IN_WIDTH:0]      acc_sum;

    // A missing sample repeats the last one (last-value hold).
    assign x_sel = bus.sample_valid ? bus.sample_in : held;
    assign x_ext = ACC_WIDTH'(x_sel);

    // Comb chain on the sample being captured; only consumed at capture edges.
    always_comb begin
        // NOTE: every element is assigned unconditionally so no latch is inferred.
        c[0] = x_ext - d[0];
        for (int i = 1; i < STAGES; i++) begin
            c[i] = c[i-1] - d[i];
        end
    end

    // Removing R^(STAGES-1) is a pure shift; the top IN_WIDTH bits remain.
    assign y = g[STAGES-1][ACC_WIDTH-1 -: IN_WIDTH];

    assign acc_sum = {1'b0, acc} + {1'b0, y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            pdm_q      <= 1'b0;
            held       <= '0;
            zs         <= '0;
            acc        <= '0;
            // NOTE: these arrays are small register banks, not RAM, so they
            // are cleared by reset like any other state.
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
                g[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make every stage read the previous
            // cycle's value, which is what the chains below rely on.
            phase      <= phase + 1'b1;
            ready_q    <= (phase == PRE_LAST_PHASE);
            underrun_q <= ready_q && !bus.sample_valid;

            if (ready_q) begin
                held <= x_sel;
                d[0] <= x_ext;
                for (int i = 1; i < STAGES; i++) begin
                    d[i] <= c[i-1];
                end
                zs <= c[STAGES-1];
            end else begin
                zs <= '0;
            end

            g[0] <= g[0] + zs;
            for (int i = 1; i < STAGES; i++) begin
                g[i] <= g[i] + g[i-1];
            end

            acc   <= acc_sum[IN_WIDTH-1:0];
            pdm_q <= acc_sum[IN_WIDTH];
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.underrun     = underrun_q;
    assign bus.pdm_out      = pdm_q;

endmodule

// File: doc/pdm_cic_interpolator.md
Name: pdm_cic_interpolator

Overview:
- Transmit-side counterpart to the team's PDM CIC decimator.
- Accepts unsigned multi-bit samples at the low rate (one per INTERP clocks).
- Upsamples them with a STAGES-order CIC interpolator (comb at low rate, zero-stuff, integrators at clk rate).
- Converts the result to a 1-bit PDM stream with a first-order sigma-delta modulator, to drive a PDM DAC or loop back into the decimator.

Parameters:
- STAGES, 2, number of comb stages and number of integrator stages (N ≥ 1).
- INTERP, 4, interpolation ratio R; must be a power of two ≥ 2.
- LOG2_INTERP, 2, log2(INTERP); must match INTERP.
- IN_WIDTH, 4, unsigned input sample width W.
- ACC_WIDTH, IN_WIDTH + (STAGES-1)*LOG2_INTERP, width of the comb and integrator datapath (derived).

Ports:
- clk  input  1  single clock; everything is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_in  input  IN_WIDTH  unsigned input sample.
- sample_valid  input  1  sample_in holds a valid sample.
- sample_ready  output  1  one-cycle request strobe; a sample is captured when valid && ready.
- underrun  output  1  one-cycle pulse when sample_ready is high and sample_valid is low.
- pdm_out  output  1  registered PDM bitstream, one bit per clk.

Behaviour:
- Reset (async assert, sync release): phase counter, all comb delays, zero-stuff register, integrators, modulator accumulator, held sample, sample_ready, underrun and pdm_out are 0.
- Phase counter, LOG2_INTERP bits:
  - Increments every clk and wraps from INTERP-1 to 0.
  - sample_ready = 1 exactly when phase == INTERP-1, registered, so it is high one cycle in every INTERP.
  - First ready is in cycle INTERP-1 after reset release.
- Capture edge E is the rising edge on which sample_ready = 1:
  - If sample_valid = 1, held sample <= sample_in.
  - If sample_valid = 0, held sample is kept (last-value hold) and underrun = 1 for the following cycle.
  - sample_valid is ignored whenever sample_ready = 0.
- Comb chain, ACC_WIDTH bits, modulo 2^ACC_WIDTH:
  - Evaluated combinationally on the sample being captured at E (zero-extended).
  - c[0] = x - d[0]; c[i] = c[i-1] - d[i].
  - At E: d[0] <= x, d[i] <= c[i-1]. Delays update only at capture edges.
- Zero-stuff register zs:
  - At E, zs <= c[STAGES-1].
  - At every other edge, zs <= 0.
  - zs is therefore nonzero for at most one cycle per INTERP.
- Integrators, registered chain, ACC_WIDTH bits, modulo arithmetic, updated every clk:
  - g[0] <= g[0] + zs; g[i] <= g[i] + g[i-1].
- Scaling: y = g[STAGES-1] >> ((STAGES-1)*LOG2_INTERP).
  - The CIC DC gain R^(STAGES-1) is removed exactly, so y is IN_WIDTH bits.
  - The CIC impulse response is non-negative, so there is no overshoot and no saturation logic.
- Modulator, register a[IN_WIDTH:0]:
  - Every clk: a <= {1'b0, a[IN_WIDTH-1:0]} + y, and pdm_out <= carry of that sum.
  - Long-run density of ones = y / 2^IN_WIDTH. y = 0 gives all zeros. Full scale 2^W-1 gives 2^W-1 ones per 2^W bits.
- Latency: a sample captured at E first affects pdm_out at edge E+3 (zs at E, g[0] at E+1, g[STAGES-1] at E+STAGES, modulator one edge later; for STAGES=2 that is E+3).
- Mid-operation reset clears all state immediately. There is no partial-sample recovery; the next capture happens at the normal first-ready position.

Test Plan:
- Reset: hold rst_n=0 with random inputs; all outputs 0. Release; sample_ready first high in cycle 3, then every 4 cycles.
- Constant x=8 (W=4, N=2, R=4), always valid: after 12 cycles, every 16-cycle window of pdm_out holds exactly 8 ones, alternating 0/1. x=0 gives constant 0. x=15 gives 15 ones per 16.
- Step 0 -> 12: y over the 4 cycles after E+2 is 3,6,9,12 (linear interpolation), then stays at 12.
- Underrun: drop sample_valid on one ready cycle while at x=5; underrun pulses exactly once, and pdm density stays 5/16 (held sample).
- Valid outside ready: toggle sample_valid and sample_in on non-ready cycles; no capture, no effect on y.
- Reset mid-stream at x=10: assert rst_n for 1 cycle at an arbitrary phase; pdm_out=0 immediately, and the normal first-ready timing and step response replay after release.
